// File: rtl/operand_fetch_stage_pkg.sv
// Shared definitions for the operand fetch stage: state encoding, shift codes
// and default datapath geometry.
package operand_fetch_stage_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_NREGS = 8;
    localparam int DEF_IMM_W = 5;
    localparam int REG_IDX_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_A = 2'd1,
        ST_LOAD_B = 2'd2,
        ST_ISSUE  = 2'd3
    } fetch_state_t;

    localparam logic [1:0] SH_PASS = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

endpackage

// File: rtl/operand_fetch_stage_gp_regfile.sv
// General-purpose register file: one synchronous write port and one
// combinational read port that forwards a same-cycle write.
module gp_regfile
    import operand_fetch_stage_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREGS = DEF_NREGS,
    parameter int IDX_W = REG_IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WIDTH-1:0] rd_data
);

    logic [NREGS*WIDTH-1:0] cells_flat;

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_cell
            logic [WIDTH-1:0] cell_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cell_reg <= '0;
                end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
                    cell_reg <= wr_data;
                end
            end

            assign cells_flat[gi*WIDTH +: WIDTH] = cell_reg;
        end
    endgenerate

    // A write landing on the register being read wins over the stored value.
    always_comb begin
        if (wr_en && (wr_idx == rd_idx)) begin
            rd_data = wr_data;
        end else begin
            rd_data = cells_flat[rd_idx*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: latches a decoded op, reads Rn then shifted Rm over two
// cycles, and holds the selected ALU operands until the ALU accepts them.
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREGS = DEF_NREGS,
    parameter int IMM_W = DEF_IMM_W,
    localparam int IDX_W = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [IDX_W-1:0] rn,
    input  logic [IDX_W-1:0] rm,
    input  logic [1:0]       sh,
    input  logic             asel,
    input  logic             bsel,
    input  logic [IMM_W-1:0] imm,
    input  logic [1:0]       aluop_in,
    input  logic             wb_en,
    input  logic [IDX_W-1:0] wb_reg,
    input  logic [WIDTH-1:0] wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ain,
    output logic [WIDTH-1:0] bin,
    output logic [1:0]       aluop
);

    fetch_state_t state_reg, state_next;

    logic [IDX_W-1:0] rn_reg, rm_reg;
    logic [1:0]       sh_reg;
    logic             asel_reg, bsel_reg;
    logic [IMM_W-1:0] imm_reg;
    logic [1:0]       aluop_reg;
    logic [WIDTH-1:0] a_reg, b_reg;

    logic [IDX_W-1:0] rd_idx;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] imm_ext;
    logic             accept;

    gp_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .IDX_W (IDX_W)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wb_en),
        .wr_idx  (wb_reg),
        .wr_data (wb_data),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    // The single read port serves Rn in LOAD_A and Rm otherwise.
    assign rd_idx = (state_reg == ST_LOAD_A) ? rn_reg : rm_reg;

    always_comb begin
        shifted = rd_data;
        case (sh_reg)
            SH_PASS: shifted = rd_data;
            SH_LSL:  shifted = {rd_data[WIDTH-2:0], 1'b0};
            SH_LSR:  shifted = {1'b0, rd_data[WIDTH-1:1]};
            SH_ASR:  shifted = {rd_data[WIDTH-1], rd_data[WIDTH-1:1]};
            default: shifted = rd_data;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        op_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    state_next = ST_LOAD_A;
                end
            end
            ST_LOAD_A: state_next = ST_LOAD_B;
            ST_LOAD_B: state_next = ST_ISSUE;
            ST_ISSUE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign accept = op_valid && op_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rn_reg    <= '0;
            rm_reg    <= '0;
            sh_reg    <= '0;
            asel_reg  <= 1'b0;
            bsel_reg  <= 1'b0;
            imm_reg   <= '0;
            aluop_reg <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
        end else begin
            if (accept) begin
                rn_reg    <= rn;
                rm_reg    <= rm;
                sh_reg    <= sh;
                asel_reg  <= asel;
                bsel_reg  <= bsel;
                imm_reg   <= imm;
                aluop_reg <= aluop_in;
            end
            if (state_reg == ST_LOAD_A) begin
                a_reg <= rd_data;
            end
            if (state_reg == ST_LOAD_B) begin
                b_reg <= shifted;
            end
        end
    end

    // The immediate bypasses the shifter entirely.
    assign imm_ext = {{(WIDTH-IMM_W){imm_reg[IMM_W-1]}}, imm_reg};

    assign ain   = asel_reg ? '0 : a_reg;
    assign bin   = bsel_reg ? imm_ext : b_reg;
    assign aluop = aluop_reg;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: directed scenarios followed by
// randomized operations with random write-back traffic, checked against a model.
module tb_operand_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  rn, rm;
    logic [1:0]  sh;
    logic        asel, bsel;
    logic [4:0]  imm;
    logic [1:0]  aluop_in;
    logic        wb_en;
    logic [2:0]  wb_reg;
    logic [15:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] ain, bin;
    logic [1:0]  aluop;

    logic [15:0] m_regs [8];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    operand_fetch_stage dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .rn        (rn),
        .rm        (rm),
        .sh        (sh),
        .asel      (asel),
        .bsel      (bsel),
        .imm       (imm),
        .aluop_in  (aluop_in),
        .wb_en     (wb_en),
        .wb_reg    (wb_reg),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ain       (ain),
        .bin       (bin),
        .aluop     (aluop)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock; the model register file takes any write present at the edge.
    task automatic step();
        @(posedge clk);
        if (reset && wb_en) m_regs[wb_reg] = wb_data;
        #1;
    endtask

    function automatic logic [15:0] ref_shift(input logic [15:0] x, input logic [1:0] code);
        logic [15:0] r;
        case (code)
            2'd0: r = x;
            2'd1: r = x * 16'd2;
            2'd2: r = x / 16'd2;
            default: r = (x / 16'd2) + ((x >= 16'h8000) ? 16'h8000 : 16'h0000);
        endcase
        return r;
    endfunction

    task automatic garbage_op();
        op_valid = 1'b1;
        rn = 3'($urandom); rm = 3'($urandom); sh = 2'($urandom);
        asel = 1'($urandom); bsel = 1'($urandom);
        imm = 5'($urandom); aluop_in = 2'($urandom);
    endtask

    task automatic drive_wb(input logic en, input logic [2:0] r, input logic [15:0] d);
        wb_en = en; wb_reg = r; wb_data = d;
    endtask

    task automatic write_reg(input logic [2:0] r, input logic [15:0] d);
        op_valid = 1'b0;
        drive_wb(1'b1, r, d);
        step();
        drive_wb(1'b0, 3'd0, 16'h0);
    endtask

    task automatic run_op(
        input logic [2:0] rn_v, input logic [2:0] rm_v, input logic [1:0] sh_v,
        input logic as_v, input logic bs_v, input logic [4:0] imm_v, input logic [1:0] op_v,
        input logic wa_en, input logic [2:0] wa_r, input logic [15:0] wa_d,
        input logic wbb_en, input logic [2:0] wbb_r, input logic [15:0] wbb_d,
        input logic wi_en, input logic [2:0] wi_r, input logic [15:0] wi_d,
        input int stall);
        logic [15:0] ea, eb, raw, exp_ain, exp_bin;
        check("op_ready_idle", 16'(op_ready), 16'd1);
        op_valid = 1'b1;
        rn = rn_v; rm = rm_v; sh = sh_v; asel = as_v; bsel = bs_v;
        imm = imm_v; aluop_in = op_v;
        drive_wb(1'b0, 3'd0, 16'h0);
        step();
        // LOAD_A cycle
        check("op_ready_busy", 16'(op_ready), 16'd0);
        check("out_valid_load_a", 16'(out_valid), 16'd0);
        garbage_op();
        drive_wb(wa_en, wa_r, wa_d);
        ea = (wa_en && wa_r == rn_v) ? wa_d : m_regs[rn_v];
        step();
        // LOAD_B cycle
        check("out_valid_load_b", 16'(out_valid), 16'd0);
        garbage_op();
        drive_wb(wbb_en, wbb_r, wbb_d);
        raw = (wbb_en && wbb_r == rm_v) ? wbb_d : m_regs[rm_v];
        eb = ref_shift(raw, sh_v);
        step();
        exp_ain = as_v ? 16'h0000 : ea;
        exp_bin = bs_v ? 16'($signed(imm_v)) : eb;
        for (int k = 0; k <= stall; k++) begin
            check("out_valid_issue", 16'(out_valid), 16'd1);
            check("ain", ain, exp_ain);
            check("bin", bin, exp_bin);
            check("aluop", 16'(aluop), 16'(op_v));
            check("op_ready_issue", 16'(op_ready), 16'd0);
            garbage_op();
            drive_wb(wi_en, wi_r, wi_d);
            out_ready = (k == stall);
            step();
        end
        out_ready = 1'b0;
        op_valid = 1'b0;
        drive_wb(1'b0, 3'd0, 16'h0);
        check("out_valid_after", 16'(out_valid), 16'd0);
        check("op_ready_after", 16'(op_ready), 16'd1);
        $display("op rn=%0d rm=%0d sh=%0d asel=%0d bsel=%0d imm=%h -> ain=%h bin=%h aluop=%0d (stall %0d)",
                 rn_v, rm_v, sh_v, as_v, bs_v, imm_v, exp_ain, exp_bin, op_v, stall);
    endtask

    initial begin
        reset = 1'b0;
        op_valid = 1'b0; out_ready = 1'b0;
        rn = '0; rm = '0; sh = '0; asel = 1'b0; bsel = 1'b0; imm = '0; aluop_in = '0;
        drive_wb(1'b0, 3'd0, 16'h0);
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 16'(out_valid), 16'd0);
        check("rst_op_ready", 16'(op_ready), 16'd1);
        check("rst_ain", ain, 16'h0);
        check("rst_bin", bin, 16'h0);
        check("rst_aluop", 16'(aluop), 16'd0);
        reset = 1'b1;
        step();

        write_reg(3'd1, 16'h0005);
        write_reg(3'd2, 16'h0003);
        write_reg(3'd4, 16'h8001);

        // basic fetch
        run_op(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 5'd0, 2'b01,
               1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 0);
        // shifts of 0x8001
        run_op(3'd0, 3'd4, 2'b01, 1'b0, 1'b0, 5'd0, 2'b10,
               1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 0);
        run_op(3'd0, 3'd4, 2'b10, 1'b0, 1'b0, 5'd0, 2'b11,
               1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1);
        run_op(3'd0, 3'd4, 2'b11, 1'b0, 1'b0, 5'd0, 2'b00,
               1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 0);
        // selects: zero A, negative immediate (shift must not touch it)
        run_op(3'd1, 3'd4, 2'b01, 1'b1, 1'b1, 5'b10110, 2'b01,
               1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 0);
        // forwarding in LOAD_A, late write during a 5-cycle stall
        run_op(3'd1, 3'd2, 2'b00, 1'b0, 1'b0, 5'd0, 2'b10,
               1'b1, 3'd1, 16'h1234, 1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 16'h9999, 5);
        // follow-up op reads the late write
        run_op(3'd1, 3'd1, 2'b00, 1'b0, 1'b0, 5'd0, 2'b00,
               1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 0);

        // reset mid-LOAD_B
        write_reg(3'd3, 16'hBEEF);
        op_valid = 1'b1; rn = 3'd3; rm = 3'd3; sh = 2'b00; asel = 1'b0; bsel = 1'b0;
        imm = '0; aluop_in = 2'b11;
        step();
        op_valid = 1'b0;
        step();
        #2;
        reset = 1'b0;
        #1;
        check("midrst_out_valid", 16'(out_valid), 16'd0);
        check("midrst_op_ready", 16'(op_ready), 16'd1);
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        $display("reset asserted during LOAD_B");
        step();
        check("midrst_hold_valid", 16'(out_valid), 16'd0);
        reset = 1'b1;
        step();
        run_op(3'd3, 3'd3, 2'b00, 1'b0, 1'b0, 5'd0, 2'b01,
               1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 0);

        // randomized ops with random write-back traffic
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 1) == 1)
                write_reg(3'($urandom), 16'($urandom));
            run_op(3'($urandom), 3'($urandom), 2'($urandom), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 3) == 0), 5'($urandom), 2'($urandom),
                   1'($urandom), 3'($urandom), 16'($urandom),
                   1'($urandom), 3'($urandom), 16'($urandom),
                   1'($urandom), 3'($urandom), 16'($urandom),
                   int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_fetch_stage.md
# operand_fetch_stage

Operand fetch stage directly upstream of the 16-bit ALU. Holds the 8-entry general-purpose register file, accepts one decoded operation through a valid/ready handshake, reads Rn into the A register and the shifted Rm into the B register over successive cycles, applies the A/B source selects, and presents `ain`, `bin` and `aluop` to the ALU with a valid/ready handshake. Also accepts the write-back of ALU results into the register file.

## Interface
- `WIDTH`, 16: datapath width. Matches the ALU operand width.
- `NREGS`, 8: register count. Index width is log2(`NREGS`) = 3.
- `IMM_W`, 5: immediate field width. The immediate is sign-extended to `WIDTH`.

- `clk`  in  1: single clock. All state changes on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `op_valid`  in  1: a decoded operation is offered.
- `op_ready`  out  1: the stage can accept an operation. High only in IDLE.
- `rn`, `rm`  in  3 each: source register indices.
- `sh`  in  2: shift code applied to Rm.
- `asel`  in  1: when 1, `ain` is forced to 0.
- `bsel`  in  1: when 1, `bin` is the sign-extended `imm`.
- `imm`  in  `IMM_W`: immediate field.
- `aluop_in`  in  2: ALU opcode, carried through unchanged.
- `wb_en`  in  1: register write enable.
- `wb_reg`  in  3: register index to write.
- `wb_data`  in  `WIDTH`: data to write.
- `out_valid`  out  1: `ain`, `bin` and `aluop` are valid.
- `out_ready`  in  1: the ALU side consumes the operands.
- `ain`, `bin`  out  `WIDTH`: ALU operands.
- `aluop`  out  2: latched ALU opcode.

## Operation
- **FSM states:** IDLE → LOAD_A → LOAD_B → ISSUE → IDLE.
- **IDLE:**
  - `op_ready` = 1.
  - On `op_valid && op_ready`, latch `rn`, `rm`, `sh`, `asel`, `bsel`, `imm`, `aluop_in`, then go to LOAD_A.
- **LOAD_A:** A ← R[rn]. Always go to LOAD_B.
- **LOAD_B:** B ← shift(R[rm], sh). Go to ISSUE.
- **Shift codes:**
  - 00: pass through.
  - 01: shift left by 1, LSB = 0.
  - 10: logical shift right by 1, MSB = 0.
  - 11: arithmetic shift right by 1, MSB kept.
- **ISSUE:**
  - `out_valid` = 1.
  - `ain` = `asel` ? 0 : A.
  - `bin` = `bsel` ? sext(imm) : B. The shift does not apply to the immediate.
  - On `out_ready`, go to IDLE. Otherwise hold, with all outputs stable.
- **Register file:**
  - Writes are synchronous: R[wb_reg] ← wb_data when `wb_en` is high.
  - Writes are accepted in every state.
- **Read forwarding:**
  - A read in LOAD_A or LOAD_B returns `wb_data` when `wb_en` is high and `wb_reg` equals the index being read in that same cycle.
  - Otherwise the read returns the stored value.
- **Writes after capture:** a write to Rn or Rm after its read cycle does not change the latched A/B.
- **Width rules:**
  - All arithmetic is unsigned bit manipulation.
  - Shifted-out bits are discarded.
  - sext replicates `imm[IMM_W-1]`.

## Timing
- **Reset** (asynchronous, `reset` = 0):
  - State goes to IDLE.
  - A, B and all registers R0–R7 are cleared to 0.
  - Latched fields are cleared to 0.
  - `out_valid` = 0, `op_ready` = 1, `ain` = `bin` = 0, `aluop` = 00.
- **Reset mid-operation:** an in-flight operation is discarded. No `out_valid` is produced for it.
- **Latency:**
  - Operation accepted at edge 0.
  - LOAD_A at edge 1, LOAD_B at edge 2.
  - `out_valid` is high from edge 3 until the edge where `out_ready` is sampled high.
- **Throughput:** at most one operation per 4 cycles. `op_ready` rises the cycle after the ISSUE handshake.
- **Handshake:** `op_valid` is ignored outside IDLE. `op_ready` is 0 there, and no field is re-latched.
- **Output stability:** `out_valid` never drops without `out_ready`. `ain`, `bin` and `aluop` are constant while `out_valid` = 1.
- **Simultaneous events:** when `wb_en` targets the register being read in the same cycle, the forwarded value is used and the array also updates at that edge.

## Structure
- **Shared package:**
  - FSM state encoding: IDLE = 2'd0, LOAD_A = 2'd1, LOAD_B = 2'd2, ISSUE = 2'd3.
  - Shift-code constants.
  - Default `WIDTH`, `IMM_W` and register index width.
- **Sub-module `gp_regfile`:**
  - 8×`WIDTH` array.
  - One synchronous write port.
  - One combinational read port with same-cycle write forwarding.
  - Asynchronous active-low clear.
- **Top level:** the shifter and the operand muxes are combinational logic in `operand_fetch_stage`.

## Test plan
- **Reset:**
  - Assert reset mid-LOAD_B → `out_valid` = 0 and `op_ready` = 1 immediately.
  - A subsequent read of R3 returns 0x0000.
- **Basic fetch:**
  - Stimulus: write R1 = 0x0005 and R2 = 0x0003. Issue `rn` = 1, `rm` = 2, `sh` = 00, `asel` = 0, `bsel` = 0, `aluop_in` = 01.
  - Required response: `out_valid` at edge 3 with `ain` = 0x0005, `bin` = 0x0003, `aluop` = 01.
- **Shifts:** R4 = 0x8001 with `sh` = 01/10/11 → `bin` = 0x0002, 0x4000, 0xC000 respectively.
- **Selects:** `asel` = 1, `bsel` = 1, `imm` = 5'b10110 → `ain` = 0x0000, `bin` = 0xFFF6.
- **Forwarding:**
  - `wb_en` with `wb_reg` = 1 and `wb_data` = 0x1234 in the LOAD_A cycle of an op with `rn` = 1 → `ain` = 0x1234.
  - A write of 0x9999 to R1 during ISSUE leaves `ain` = 0x1234.
- **Backpressure:**
  - Hold `out_ready` = 0 for 5 cycles → outputs stable, `op_ready` = 0, a new `op_valid` is ignored.
  - Release `out_ready` → IDLE the next cycle, and the next op is accepted.
